pupil_locator: RTL

Streaming pupil finder that consumes the grayscale pixel stream and produces the marker position consumed by the box-overlay stage. Each pixel is classified dark or not against a threshold. Coordinates of dark pixels are accumulated over a frame. At the next start-of-frame a serial divider computes the centroid, which is published as a registered position with a one-cycle valid strobe.

---
 rtl/pupil_pkg.sv | 23 ++
 rtl/serial_divider.sv | 77 +++++++
 rtl/pupil_locator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pupil_pkg.sv
// Shared types and constants for the pupil locator.
// The bounding-box outputs are built only when PUPIL_BBOX_EN is defined.
package pupil_pkg;

   localparam int unsigned COORD_W = 13;
   localparam int unsigned OUT_W   = 16;

   localparam logic [COORD_W-1:0] BBOX_MIN_RST = 13'd8191;
   localparam logic [COORD_W-1:0] BBOX_MAX_RST = 13'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DIV_X = 2'd1,
      DIV_Y = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Zero-extend a pixel coordinate to the published position width.
   function automatic logic [OUT_W-1:0] zext_coord(input logic [COORD_W-1:0] c);
      return OUT_W'(c);
   endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// The start cycle performs the first step directly from the dividend/divisor
// inputs, so a division takes exactly SUM_W clocks including the start cycle.
module serial_divider import pupil_pkg::*; #(
   parameter int unsigned SUM_W = 36
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SUM_W-1:0]    dividend,
   input  logic [SUM_W-1:0]    divisor,
   output logic                done,
   output logic [COORD_W-1:0]  quotient
);

   localparam int unsigned STEP_W = $clog2(SUM_W + 1);

   logic [SUM_W-1:0]  rem;
   logic [SUM_W-1:0]  quo;
   logic [SUM_W-1:0]  dvs;
   logic [STEP_W-1:0] steps;
   logic              busy;

   logic [SUM_W-1:0]  rem_in;
   logic [SUM_W-1:0]  quo_in;
   logic [SUM_W-1:0]  dvs_in;
   logic [SUM_W:0]    trial;
   logic [SUM_W-1:0]  rem_nxt;
   logic [SUM_W-1:0]  quo_nxt;

   // One restoring step; on start the operands come straight from the inputs.
   always_comb begin
      rem_in = start ? '0 : rem;
      quo_in = start ? dividend : quo;
      dvs_in = start ? divisor : dvs;
      trial  = {rem_in, quo_in[SUM_W-1]};
      if (trial >= {1'b0, dvs_in}) begin
         rem_nxt = SUM_W'(trial - {1'b0, dvs_in});
         quo_nxt = {quo_in[SUM_W-2:0], 1'b1};
      end else begin
         rem_nxt = trial[SUM_W-1:0];
         quo_nxt = {quo_in[SUM_W-2:0], 1'b0};
      end
   end

   // Iteration registers, step counter and end-of-division strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         steps <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
         end
         if (start) begin
            dvs   <= divisor;
            busy  <= 1'b1;
            steps <= STEP_W'(1);
         end else if (busy) begin
            steps <= steps + STEP_W'(1);
            if (steps == STEP_W'(SUM_W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo[COORD_W-1:0];

endmodule

// File: rtl/pupil_locator.sv
// Streaming dark-pixel centroid finder. Accumulates dark-pixel coordinates
// over a frame and publishes the centroid after the next start-of-frame.
// Optional bounding-box outputs: define PUPIL_BBOX_EN.
module pupil_locator import pupil_pkg::*; #(
   parameter int unsigned CNT_W   = 22,
   parameter int unsigned SUM_W   = 36,
   parameter int unsigned MIN_PIX = 64
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iDVAL,
   input  logic [12:0] iH_Cont,
   input  logic [12:0] iV_Cont,
   input  logic [9:0]  iGray,
   input  logic [9:0]  iThreshold,
   output logic [15:0] oPos_X,
   output logic [15:0] oPos_Y,
   output logic        oFound,
   output logic        oPos_Valid,
   output logic        oOverrun
`ifdef PUPIL_BBOX_EN
   ,
   output logic [15:0] oMinX,
   output logic [15:0] oMaxX,
   output logic [15:0] oMinY,
   output logic [15:0] oMaxY
`endif
);

   localparam int unsigned BIT_W = $clog2(SUM_W);

   logic dark;
   logic sof;

   logic [CNT_W-1:0]   cnt;
   logic [SUM_W-1:0]   sum_x;
   logic [SUM_W-1:0]   sum_y;
   logic [CNT_W-1:0]   cnt_inc;
   logic [SUM_W:0]     sum_x_add;
   logic [SUM_W:0]     sum_y_add;
   logic [SUM_W-1:0]   sum_x_sat;
   logic [SUM_W-1:0]   sum_y_sat;

   state_t             state;
   logic [BIT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   cnt_snap;
   logic [SUM_W-1:0]   sum_x_snap;
   logic [SUM_W-1:0]   sum_y_snap;
   logic [COORD_W-1:0] quo_x;

   logic               div_start;
   logic [SUM_W-1:0]   div_dividend;
   logic [SUM_W-1:0]   div_divisor;
   logic               div_done;
   logic [COORD_W-1:0] div_quotient;

   assign dark = iDVAL && (iGray < iThreshold);
   assign sof  = iDVAL && (iH_Cont == 13'd0) && (iV_Cont == 13'd0);

   // Saturating next values for the frame accumulators.
   always_comb begin
      cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
      sum_x_add = {1'b0, sum_x} + (SUM_W + 1)'(iH_Cont);
      sum_y_add = {1'b0, sum_y} + (SUM_W + 1)'(iV_Cont);
      sum_x_sat = sum_x_add[SUM_W] ? '1 : sum_x_add[SUM_W-1:0];
      sum_y_sat = sum_y_add[SUM_W] ? '1 : sum_y_add[SUM_W-1:0];
   end

   // Frame accumulators; reloaded with the SOF pixel's own contribution.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         cnt   <= '0;
         sum_x <= '0;
         sum_y <= '0;
      end else if (sof) begin
         cnt   <= dark ? CNT_W'(1) : '0;
         sum_x <= '0;
         sum_y <= '0;
      end else if (dark) begin
         cnt   <= cnt_inc;
         sum_x <= sum_x_sat;
         sum_y <= sum_y_sat;
      end
   end

   // The single divider is started at the first cycle of each divide state.
   assign div_start    = ((state == DIV_X) || (state == DIV_Y)) && (bit_cnt == '0);
   assign div_dividend = (state == DIV_Y) ? sum_y_snap : sum_x_snap;
   assign div_divisor  = SUM_W'(cnt_snap);

   serial_divider #(
      .SUM_W (SUM_W)
   ) u_div (
      .clk      (iCLK),
      .rst_n    (iRST),
      .start    (div_start),
      .dividend (div_dividend),
      .divisor  (div_divisor),
      .done     (div_done),
      .quotient (div_quotient)
   );

`ifdef PUPIL_BBOX_EN
   logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
   logic [COORD_W-1:0] min_x_snap, max_x_snap, min_y_snap, max_y_snap;

   // Per-frame dark-pixel extents; a dark SOF pixel seeds them at (0,0).
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         min_x <= BBOX_MIN_RST;
         max_x <= BBOX_MAX_RST;
         min_y <= BBOX_MIN_RST;
         max_y <= BBOX_MAX_RST;
      end else if (sof) begin
         min_x <= dark ? '0 : BBOX_MIN_RST;
         max_x <= BBOX_MAX_RST;
         min_y <= dark ? '0 : BBOX_MIN_RST;
         max_y <= BBOX_MAX_RST;
      end else if (dark) begin
         if (iH_Cont < min_x) min_x <= iH_Cont;
         if (iH_Cont > max_x) max_x <= iH_Cont;
         if (iV_Cont < min_y) min_y <= iV_Cont;
         if (iV_Cont > max_y) max_y <= iV_Cont;
      end
   end
`endif

   // Control FSM: snapshot at SOF, divide X then Y, publish at DONE.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         cnt_snap   <= '0;
         sum_x_snap <= '0;
         sum_y_snap <= '0;
         quo_x      <= '0;
         oPos_X     <= '0;
         oPos_Y     <= '0;
         oFound     <= 1'b0;
         oPos_Valid <= 1'b0;
         oOverrun   <= 1'b0;
`ifdef PUPIL_BBOX_EN
         min_x_snap <= '0;
         max_x_snap <= '0;
         min_y_snap <= '0;
         max_y_snap <= '0;
         oMinX      <= '0;
         oMaxX      <= '0;
         oMinY      <= '0;
         oMaxY      <= '0;
`endif
      end else begin
         oPos_Valid <= 1'b0;
         oOverrun   <= sof && (state != IDLE);
         case (state)
            IDLE: begin
               if (sof) begin
                  cnt_snap   <= cnt;
                  sum_x_snap <= sum_x;
                  sum_y_snap <= sum_y;
`ifdef PUPIL_BBOX_EN
                  min_x_snap <= min_x;
                  max_x_snap <= max_x;
                  min_y_snap <= min_y;
                  max_y_snap <= max_y;
`endif
                  bit_cnt    <= '0;
                  state      <= DIV_X;
               end
            end
            DIV_X: begin
               if (bit_cnt == BIT_W'(SUM_W - 1)) begin
                  bit_cnt <= '0;
                  state   <= DIV_Y;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            DIV_Y: begin
               if (div_done) quo_x <= div_quotient;
               if (bit_cnt == BIT_W'(SUM_W - 1)) begin
                  bit_cnt <= '0;
                  state   <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            DONE: begin
               oPos_Valid <= 1'b1;
               if (cnt_snap >= CNT_W'(MIN_PIX)) begin
                  oPos_X <= zext_coord(quo_x);
                  oPos_Y <= zext_coord(div_quotient);
                  oFound <= 1'b1;
`ifdef PUPIL_BBOX_EN
                  oMinX  <= zext_coord(min_x_snap);
                  oMaxX  <= zext_coord(max_x_snap);
                  oMinY  <= zext_coord(min_y_snap);
                  oMaxY  <= zext_coord(max_y_snap);
`endif
               end else begin
                  oFound <= 1'b0;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
